iob_wb2iob_arbiter: RTL and testbench
=====================================

# iob_wb2iob_arbiter

Two-master Wishbone-to-IOb arbiter that shares a single IOb slave port between two Wishbone masters, e.g. the MAC DMA master and the host CPU. It uses round-robin arbitration and registers the winning request onto the IOb port. It holds `valid_o` until the slave returns `ready_i`, routes the response to the granted master, and aborts hung transfers with a watchdog. It sits between the Wishbone masters and the shared IOb memory/peripheral port.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; byte lanes = `DATA_W/8`
- `TIMEOUT_W`, 8, watchdog counter width; 0 disables the watchdog

Ports (k = 0, 1):
- `clk_i` in 1: clock; all logic on the rising edge
- `arst_i` in 1: reset, asynchronous, active-high
- `mk_addr_i` in `ADDR_W`: master k address
- `mk_select_i` in `DATA_W/8`: master k byte select
- `mk_we_i` in 1: master k write enable
- `mk_cyc_i` in 1: master k cycle
- `mk_stb_i` in 1: master k strobe
- `mk_data_i` in `DATA_W`: master k write data
- `mk_ack_o` out 1: master k acknowledge
- `mk_error_o` out 1: master k error (timeout)
- `mk_data_o` out `DATA_W`: master k read data
- `valid_o` out 1: IOb request valid, registered
- `address_o` out `ADDR_W`: IOb address, registered
- `wdata_o` out `DATA_W`: IOb write data, registered
- `wstrb_o` out `DATA_W/8`: IOb write strobe, registered; all-zero means read
- `rdata_i` in `DATA_W`: IOb read data
- `ready_i` in 1: IOb ready/acknowledge

## Operation
- A request from master k is `mk_cyc_i & mk_stb_i`.
- State machine states: `IDLE` and `BUSY`.
- **IDLE**
  - If exactly one master requests, grant it.
  - If both request, grant the master not served last. The `last` pointer resets to 1, so m0 wins the first tie.
  - On a grant: capture address, data and `wstrb = we ? select : 0` into the IOb registers; set `valid_o <= 1`; set `gnt <= k`; update `last <= k`; go to BUSY.
- **BUSY**
  - `valid_o` and the captured fields stay stable.
  - If `ready_i` = 1: `mk_ack_o` for the granted master is combinational (`ready_i & BUSY & gnt==k`), and `mk_data_o = rdata_i`. Next cycle: `valid_o` = 0, state = IDLE, watchdog cleared.
  - Watchdog: the counter increments each BUSY cycle without `ready_i`. When it reaches `2^TIMEOUT_W-1` (and `TIMEOUT_W` > 0):
    - assert `mk_error_o` to the granted master for one cycle (combinational, same cycle as terminal count);
    - next cycle: `valid_o` = 0, state = IDLE.
  - `ready_i` in the terminal-count cycle wins: ack, no error.
- The non-granted master sees ack = 0 and error = 0. It keeps its request pending and is not lost.
- If the granted master drops `cyc` mid-BUSY, the IOb transfer still completes (IOb cannot abort). Its ack/error is gated by the live `mk_cyc_i`, so a stale response never reaches the master.
- `ready_i` in IDLE is ignored.
- `mk_data_o` equals `rdata_i` for both masters (ack qualifies it).

## Timing
- Reset values: `valid_o` = 0; `address_o`, `wdata_o`, `wstrb_o` = 0; state = IDLE; `gnt` = 0; `last` = 1; watchdog = 0. All acks and errors are 0.
- Request seen in IDLE at cycle N gives `valid_o` = 1 at N+1. The earliest ack is at N+1 (`ready_i` at N+1). Minimum transfer is 2 cycles.
- Back-to-back transfers: the earliest next grant is at IDLE cycle N+2, so `valid_o` is low for at least one cycle between transfers.
- Both masters requesting continuously strictly alternate: m0, m1, m0, …
- Reset mid-transfer: immediate return to reset values; the pending IOb transfer is dropped.

## Structure
- Shared package `iob_arb_pkg` holds the state encoding (`IDLE`=0, `BUSY`=1) and the master index width constant.
- Sub-module `iob_rr_arbiter2`: combinational two-way round-robin picker. Inputs: req[1:0], last. Outputs: gnt_valid, gnt_idx.

## Test plan
- Reset: assert `arst_i` asynchronously mid-cycle -> all outputs 0 at once; first request after release granted to m0 on a tie.
- Single read: m0 reads 0x100, slave returns `ready_i` 3 cycles after `valid_o` with rdata 0xDEADBEEF -> `m0_ack_o` for exactly one cycle, `m0_data_o` = 0xDEADBEEF, `wstrb_o` = 0.
- Contention: both masters write continuously (m0 to 0x10, m1 to 0x20, select 0xF) -> IOb sees 0x10, 0x20, 0x10, 0x20…, `wstrb_o` = 0xF, and each master is acked only for its own transfer.
- Watchdog: `TIMEOUT_W` = 4, slave never ready -> `m1_error_o` one pulse at cycle 15 of BUSY, `valid_o` low the next cycle, no ack.
- Abort: m0 drops `cyc` in BUSY, slave ready later -> no `m0_ack_o`, `valid_o` drops next cycle, pending m1 granted afterwards.
- Ready/timeout tie: `ready_i` coincides with terminal count -> ack asserted, error not asserted.

Source files
------------

// File: rtl/iob_arb_pkg.sv
// Shared definitions for the two-master Wishbone-to-IOb arbiter:
// FSM encoding and the master index type.
package iob_arb_pkg;

    localparam int MIDX_W = 1;

    typedef logic [MIDX_W-1:0] midx_t;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

endpackage

// File: rtl/iob_rr_arbiter2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// on a tie the master that was not served last wins.
module iob_rr_arbiter2
    import iob_arb_pkg::*;
(
    input  logic [1:0] req,
    input  midx_t      last,
    output logic       gnt_valid,
    output midx_t      gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = MIDX_W'(0);
        case (req)
            2'b10:   gnt_idx = MIDX_W'(1);
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = MIDX_W'(0);
        endcase
    end

endmodule

// File: rtl/iob_wb2iob_arbiter.sv
// Shares one IOb slave port between two Wishbone masters with round-robin
// arbitration, registered request fields and a watchdog for hung transfers.
module iob_wb2iob_arbiter
    import iob_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_i,

    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W/8-1:0] m0_select_i,
    input  logic                m0_we_i,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic [DATA_W-1:0]   m0_data_i,
    output logic                m0_ack_o,
    output logic                m0_error_o,
    output logic [DATA_W-1:0]   m0_data_o,

    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W/8-1:0] m1_select_i,
    input  logic                m1_we_i,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic [DATA_W-1:0]   m1_data_i,
    output logic                m1_ack_o,
    output logic                m1_error_o,
    output logic [DATA_W-1:0]   m1_data_o,

    output logic                valid_o,
    output logic [ADDR_W-1:0]   address_o,
    output logic [DATA_W-1:0]   wdata_o,
    output logic [DATA_W/8-1:0] wstrb_o,
    input  logic [DATA_W-1:0]   rdata_i,
    input  logic                ready_i
);

    localparam int CNT_W = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
    // Counter value during the last non-ready cycle before abort
    localparam logic [CNT_W-1:0] TERM = CNT_W'((2 ** TIMEOUT_W) - 2);

    logic [0:0]       state;
    midx_t            gnt;
    midx_t            last;
    logic [CNT_W-1:0] wdog;

    logic             gnt_valid;
    midx_t            gnt_idx;
    logic             busy;
    logic             timeout;
    logic             pick_m1;

    iob_rr_arbiter2 u_rr (
        .req       ({m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i}),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign busy    = (state == BUSY);
    assign pick_m1 = (gnt_idx == MIDX_W'(1));
    assign timeout = (TIMEOUT_W > 0) && busy && !ready_i && (wdog == TERM);

    // Responses go only to the granted master and only while it still holds cyc
    assign m0_ack_o   = ready_i & busy & (gnt == MIDX_W'(0)) & m0_cyc_i;
    assign m1_ack_o   = ready_i & busy & (gnt == MIDX_W'(1)) & m1_cyc_i;
    assign m0_error_o = timeout & (gnt == MIDX_W'(0)) & m0_cyc_i;
    assign m1_error_o = timeout & (gnt == MIDX_W'(1)) & m1_cyc_i;
    assign m0_data_o  = rdata_i;
    assign m1_data_o  = rdata_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state     <= IDLE;
            gnt       <= MIDX_W'(0);
            last      <= MIDX_W'(1);
            wdog      <= '0;
            valid_o   <= 1'b0;
            address_o <= '0;
            wdata_o   <= '0;
            wstrb_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        address_o <= pick_m1 ? m1_addr_i : m0_addr_i;
                        wdata_o   <= pick_m1 ? m1_data_i : m0_data_i;
                        if (pick_m1)
                            wstrb_o <= m1_we_i ? m1_select_i : '0;
                        else
                            wstrb_o <= m0_we_i ? m0_select_i : '0;
                        valid_o <= 1'b1;
                        gnt     <= gnt_idx;
                        last    <= gnt_idx;
                        wdog    <= '0;
                        state   <= BUSY;
                    end
                end
                default: begin
                    // The IOb side cannot abort, so only ready or the watchdog end a transfer
                    if (ready_i || timeout) begin
                        valid_o <= 1'b0;
                        wdog    <= '0;
                        state   <= IDLE;
                    end else begin
                        wdog <= wdog + CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iob_wb2iob_arbiter.sv
// Self-checking bench for iob_wb2iob_arbiter: table-driven single transfers
// plus hand-written contention, watchdog, abort and reset sequences.
module tb_iob_wb2iob_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT_W = 4;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        wstrb;
    } exp_t;

    typedef struct {
        int                master;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        sel;
        logic [DATA_W-1:0] rdata;
        int                delay;
        logic [3:0]        expWstrb;
    } vec_t;

    logic              clk_i = 1'b0;
    logic              arst_i = 1'b1;
    logic [ADDR_W-1:0] m0_addr_i = '0, m1_addr_i = '0;
    logic [3:0]        m0_select_i = '0, m1_select_i = '0;
    logic              m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic              m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
    logic              m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic [DATA_W-1:0] m0_data_i = '0, m1_data_i = '0;
    logic              m0_ack_o, m1_ack_o, m0_error_o, m1_error_o;
    logic [DATA_W-1:0] m0_data_o, m1_data_o;
    logic              valid_o;
    logic [ADDR_W-1:0] address_o;
    logic [DATA_W-1:0] wdata_o;
    logic [3:0]        wstrb_o;
    logic [DATA_W-1:0] rdata_i = '0;
    logic              ready_i = 1'b0;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    vec_t vecs[5];

    iob_wb2iob_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .m0_addr_i   (m0_addr_i),
        .m0_select_i (m0_select_i),
        .m0_we_i     (m0_we_i),
        .m0_cyc_i    (m0_cyc_i),
        .m0_stb_i    (m0_stb_i),
        .m0_data_i   (m0_data_i),
        .m0_ack_o    (m0_ack_o),
        .m0_error_o  (m0_error_o),
        .m0_data_o   (m0_data_o),
        .m1_addr_i   (m1_addr_i),
        .m1_select_i (m1_select_i),
        .m1_we_i     (m1_we_i),
        .m1_cyc_i    (m1_cyc_i),
        .m1_stb_i    (m1_stb_i),
        .m1_data_i   (m1_data_i),
        .m1_ack_o    (m1_ack_o),
        .m1_error_o  (m1_error_o),
        .m1_data_o   (m1_data_o),
        .valid_o     (valid_o),
        .address_o   (address_o),
        .wdata_o     (wdata_o),
        .wstrb_o     (wstrb_o),
        .rdata_i     (rdata_i),
        .ready_i     (ready_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic ackOf(input int m);
        return (m == 1) ? m1_ack_o : m0_ack_o;
    endfunction

    function automatic logic errOf(input int m);
        return (m == 1) ? m1_error_o : m0_error_o;
    endfunction

    function automatic logic [DATA_W-1:0] dataOf(input int m);
        return (m == 1) ? m1_data_o : m0_data_o;
    endfunction

    // Drives one master's request and records the IOb transfer it should produce
    task automatic applyStimulus(input int m, input logic req, input logic we,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                 input logic [3:0] sel);
        exp_t e;
        if (m == 0) begin
            m0_cyc_i = req; m0_stb_i = req; m0_we_i = we;
            m0_addr_i = addr; m0_data_i = data; m0_select_i = sel;
        end else begin
            m1_cyc_i = req; m1_stb_i = req; m1_we_i = we;
            m1_addr_i = addr; m1_data_i = data; m1_select_i = sel;
        end
        if (req) begin
            e.addr  = addr;
            e.wdata = data;
            e.wstrb = we ? sel : 4'h0;
            sbq.push_back(e);
        end
    endtask

    task automatic dropReq(input int m);
        if (m == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
        else        begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
    endtask

    // Waits (bounded) for valid_o, then compares the IOb fields with the scoreboard head
    task automatic expectGrant(input string name);
        logic ok;
        exp_t e;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (valid_o) begin ok = 1'b1; break; end
        end
        checkOutput({name, "_grant_seen"}, {31'b0, ok}, 32'd1);
        if (ok) begin
            if (sbq.size() == 0) begin
                checkOutput({name, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                checkOutput({name, "_addr"},  address_o, e.addr);
                checkOutput({name, "_wdata"}, wdata_o,   e.wdata);
                checkOutput({name, "_wstrb"}, {28'b0, wstrb_o}, {28'b0, e.wstrb});
            end
        end
    endtask

    initial begin
        int errCycle;
        logic ackSeen;

        vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0,         4'hF, 32'hDEAD_BEEF, 3,  4'h0};
        vecs[1] = '{1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'h3, 32'h0,         0,  4'h3};
        vecs[2] = '{0, 1'b1, 32'h0000_0300, 32'hA5A5_A5A5, 4'hC, 32'h1111_2222, 1,  4'hC};
        vecs[3] = '{1, 1'b0, 32'h0000_0404, 32'hFFFF_FFFF, 4'h1, 32'h0BAD_F00D, 5,  4'h0};
        vecs[4] = '{1, 1'b1, 32'h0000_0808, 32'hCAFE_0001, 4'hF, 32'h7777_0000, 13, 4'hF};

        // Reset values
        tick();
        tick();
        checkOutput("rst_valid",  {31'b0, valid_o}, 32'd0);
        checkOutput("rst_addr",   address_o, 32'd0);
        checkOutput("rst_wstrb",  {28'b0, wstrb_o}, 32'd0);
        checkOutput("rst_acks",   {30'b0, m1_ack_o, m0_ack_o}, 32'd0);
        arst_i = 1'b0;

        // Asynchronous reset in the middle of an acked BUSY cycle
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0700, 32'h0700_0700, 4'hF);
        expectGrant("prerst");
        ready_i = 1'b1;
        rdata_i = 32'h5A5A_0000;
        #1;
        checkOutput("prerst_ack", {31'b0, m1_ack_o}, 32'd1);
        #1;
        arst_i = 1'b1;
        #1;
        checkOutput("arst_valid", {31'b0, valid_o}, 32'd0);
        checkOutput("arst_addr",  address_o, 32'd0);
        checkOutput("arst_wdata", wdata_o, 32'd0);
        checkOutput("arst_wstrb", {28'b0, wstrb_o}, 32'd0);
        checkOutput("arst_ack",   {31'b0, m1_ack_o}, 32'd0);
        dropReq(1);
        ready_i = 1'b0;
        tick();
        arst_i = 1'b0;

        // Continuous contention: strict alternation starting with m0 after reset
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0010, 32'hAAAA_0000, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_0000, 4'hF);
        applyStimulus(0, 1'b1, 1'b1, 32'h0000_0010, 32'hAAAA_0000, 4'hF);
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0020, 32'h5555_0000, 4'hF);
        for (int i = 0; i < 4; i++) begin
            expectGrant($sformatf("cont%0d", i));
            ready_i = 1'b1;
            rdata_i = 32'(i);
            #1;
            checkOutput($sformatf("cont%0d_own_ack", i),   {31'b0, ackOf(i % 2)},       32'd1);
            checkOutput($sformatf("cont%0d_other_ack", i), {31'b0, ackOf(1 - (i % 2))}, 32'd0);
            tick();
            ready_i = 1'b0;
            if (i == 3) begin dropReq(0); dropReq(1); end
            checkOutput($sformatf("cont%0d_gap", i), {31'b0, valid_o}, 32'd0);
        end

        // Table of single transfers with varying slave latency
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].master, 1'b1, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].sel);
            expectGrant($sformatf("vec%0d", v));
            checkOutput($sformatf("vec%0d_tbl_wstrb", v), {28'b0, wstrb_o}, {28'b0, vecs[v].expWstrb});
            for (int d = 0; d < vecs[v].delay; d++) begin
                #1;
                checkOutput($sformatf("vec%0d_early_ack", v), {31'b0, ackOf(vecs[v].master)}, 32'd0);
                tick();
            end
            checkOutput($sformatf("vec%0d_valid_held", v), {31'b0, valid_o}, 32'd1);
            checkOutput($sformatf("vec%0d_addr_held", v), address_o, vecs[v].addr);
            ready_i = 1'b1;
            rdata_i = vecs[v].rdata;
            #1;
            checkOutput($sformatf("vec%0d_ack", v),       {31'b0, ackOf(vecs[v].master)},     32'd1);
            checkOutput($sformatf("vec%0d_other_ack", v), {31'b0, ackOf(1 - vecs[v].master)}, 32'd0);
            checkOutput($sformatf("vec%0d_err", v),       {31'b0, errOf(vecs[v].master)},     32'd0);
            checkOutput($sformatf("vec%0d_rdata", v),     dataOf(vecs[v].master), vecs[v].rdata);
            tick();
            ready_i = 1'b0;
            dropReq(vecs[v].master);
            #1;
            checkOutput($sformatf("vec%0d_valid_drop", v), {31'b0, valid_o}, 32'd0);
            checkOutput($sformatf("vec%0d_ack_once", v),   {31'b0, ackOf(vecs[v].master)}, 32'd0);
        end

        // Watchdog: slave never ready, error on the 15th BUSY cycle
        applyStimulus(1, 1'b1, 1'b0, 32'h0000_0900, 32'h0, 4'hF);
        expectGrant("wdog");
        errCycle = 0;
        ackSeen = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (m1_ack_o) ackSeen = 1'b1;
            if (m1_error_o || m0_error_o) begin errCycle = c; break; end
            tick();
        end
        checkOutput("wdog_err_cycle", 32'(errCycle), 32'd15);
        checkOutput("wdog_err_m1",    {31'b0, m1_error_o}, 32'd1);
        checkOutput("wdog_err_m0",    {31'b0, m0_error_o}, 32'd0);
        checkOutput("wdog_no_ack",    {31'b0, ackSeen}, 32'd0);
        tick();
        dropReq(1);
        checkOutput("wdog_valid_drop", {31'b0, valid_o}, 32'd0);
        checkOutput("wdog_err_pulse",  {31'b0, m1_error_o}, 32'd0);

        // Ready coinciding with terminal count: ack wins over error
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0, 4'hF);
        expectGrant("tie");
        for (int c = 1; c < 15; c++) tick();
        ready_i = 1'b1;
        rdata_i = 32'h0000_7E57;
        #1;
        checkOutput("tie_ack", {31'b0, m0_ack_o}, 32'd1);
        checkOutput("tie_err", {31'b0, m0_error_o}, 32'd0);
        tick();
        ready_i = 1'b0;
        dropReq(0);
        checkOutput("tie_valid_drop", {31'b0, valid_o}, 32'd0);

        // Abort: m0 drops cyc mid-transfer, pending m1 is served afterwards
        applyStimulus(0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
        expectGrant("abort_m0");
        applyStimulus(1, 1'b1, 1'b1, 32'h0000_0600, 32'h0600_0600, 4'hF);
        tick();
        dropReq(0);
        tick();
        ready_i = 1'b1;
        #1;
        checkOutput("abort_m0_ack", {31'b0, m0_ack_o}, 32'd0);
        checkOutput("abort_m1_ack", {31'b0, m1_ack_o}, 32'd0);
        tick();
        ready_i = 1'b0;
        checkOutput("abort_valid_drop", {31'b0, valid_o}, 32'd0);
        expectGrant("abort_m1");
        ready_i = 1'b1;
        #1;
        checkOutput("abort_m1_served", {31'b0, m1_ack_o}, 32'd1);
        tick();
        ready_i = 1'b0;
        dropReq(1);

        // Ready in IDLE with cyc but no strobe is ignored
        m0_cyc_i = 1'b1;
        ready_i  = 1'b1;
        #1;
        checkOutput("idle_ready_ack", {31'b0, m0_ack_o}, 32'd0);
        tick();
        checkOutput("idle_ready_valid", {31'b0, valid_o}, 32'd0);
        ready_i  = 1'b0;
        m0_cyc_i = 1'b0;

        checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
